dual_port_ram_be: RTL

Parametrised true dual-port synchronous RAM that generalises the 8-bit/256-entry dual-port RAM. It adds configurable width and depth, per-byte write enables, and a selectable read-during-write mode. It also adds deterministic cross-port collision resolution with a reported collision flag, and an optional post-reset zero-fill sweep. It sits between two independent requesters (e.g. a producer and a consumer datapath) sharing one storage array on a single clock.

---
 rtl/dual_port_ram_be.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM, single clock, per-byte write enables.
// Deterministic cross-port collision merge and optional zero-fill sweep.
module dual_port_ram_be #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int RDW_MODE       = 0,
    parameter int COLL_PRIO      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   din_a,
    output logic [DATA_W-1:0]   dout_a,
    output logic                valid_a,
    input  logic                en_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   din_b,
    output logic [DATA_W-1:0]   dout_b,
    output logic                valid_b,
    output logic                busy,
    output logic                collision,
    output logic [ADDR_W-1:0]   coll_addr
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_a_q, dout_a_d;
    logic [DATA_W-1:0] dout_b_q, dout_b_d;
    logic              valid_a_q, valid_a_d;
    logic              valid_b_q, valid_b_d;
    logic              coll_q, coll_d;
    logic [ADDR_W-1:0] coll_addr_q, coll_addr_d;

    logic              ready;
    logic              acc_a, acc_b;
    logic              wr_a, wr_b;
    logic              same;
    logic              both_wr;
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] new_a, new_b;
    logic [DATA_W-1:0] coll_word;
    logic [DATA_W-1:0] post_a, post_b;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] din,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            coll_q      <= 1'b0;
            coll_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            valid_a_q   <= valid_a_d;
            valid_b_q   <= valid_b_d;
            coll_q      <= coll_d;
            coll_addr_q <= coll_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_READY;
            end
            S_READY: state_d = S_READY;
            default: state_d = RST_STATE;
        endcase
    end

    // Access datapath
    always_comb begin
        ready   = (state_q == S_READY);
        acc_a   = ready & en_a;
        acc_b   = ready & en_b;
        wr_a    = acc_a & we_a;
        wr_b    = acc_b & we_b;
        same    = (addr_a == addr_b);
        both_wr = wr_a & wr_b & same;
        old_a   = mem[addr_a];
        old_b   = mem[addr_b];
        new_a   = merge_bytes(old_a, din_a, be_a);
        new_b   = merge_bytes(old_b, din_b, be_b);
        // Loser's bytes first, winner's bytes overlaid on top
        if (COLL_PRIO == 0) coll_word = merge_bytes(new_b, din_a, be_a);
        else                coll_word = merge_bytes(new_a, din_b, be_b);
        post_a = both_wr ? coll_word : new_a;
        post_b = both_wr ? coll_word : new_b;
    end

    // Output-register inputs
    always_comb begin
        dout_a_d    = dout_a_q;
        dout_b_d    = dout_b_q;
        valid_a_d   = acc_a;
        valid_b_d   = acc_b;
        coll_d      = acc_a & acc_b & same & (we_a | we_b);
        coll_addr_d = coll_d ? addr_a : coll_addr_q;
        if (acc_a) dout_a_d = (RDW_MODE == 1 && wr_a) ? post_a : old_a;
        if (acc_b) dout_b_d = (RDW_MODE == 1 && wr_b) ? post_b : old_b;
    end

    // Storage array has no reset; the sweep provides the zero fill
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt_q[ADDR_W-1:0]] <= '0;
        end else begin
            if (wr_a) mem[addr_a] <= post_a;
            if (wr_b) mem[addr_b] <= post_b;
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q == S_CLEAR);
        dout_a    = dout_a_q;
        dout_b    = dout_b_q;
        valid_a   = valid_a_q;
        valid_b   = valid_b_q;
        collision = coll_q;
        coll_addr = coll_addr_q;
    end

endmodule
